bcnn_conv_sequencer: RTL and testbench
======================================

# bcnn_conv_sequencer

- Run-level controller for the single-stage binary CNN.
- On `dut_run` it does the following:
  - fetches one 3x3 binary kernel from weight memory;
  - fetches a count N and N packed 4x4 binary input matrices from SRAM;
  - runs each matrix through the 4-output XNOR/popcount convolution core;
  - writes each 4-bit result back to SRAM.
- Sits between the testbench/host run handshake and the SRAM/WMEM ports, replacing free-running convolution with a sequenced, multi-matrix job.

## Interface
- `OUT_BASE`, default 12'h800: SRAM address of the result for matrix 0.
- `clk` input 1: single clock, rising edge.
- `reset_b` input 1: asynchronous, active-low reset.
- `dut_run` input 1: start request, sampled only in IDLE.
- `dut_busy` output 1: high while a job is in progress.
- `dut_sram_read_address` output 12: SRAM read address.
- `sram_dut_read_data` input 16: SRAM read data, valid the cycle after its address is visible.
- `dut_wmem_read_address` output 12: weight memory read address.
- `wmem_dut_read_data` input 16: WMEM read data, same latency as SRAM.
- `dut_sram_write_address` output 12: SRAM write address.
- `dut_sram_write_data` output 16: SRAM write data.
- `dut_sram_write_enable` output 1: one-cycle write strobe.

## Operation
- Memory map:
  - WMEM[0][8:0] is the kernel, tap k = r*3+c.
  - SRAM[0][10:0] is N; bits [15:11] are ignored.
  - SRAM[1+i] holds matrix i, bit r*4+c = element (r,c).
  - Results go to SRAM[OUT_BASE+i] as {12'b0, res[3:0]}.
- Convolution:
  - Window j has base offset 0, 1, 4, 5 for j = 0..3.
  - Tap k of window j compares in[base+r*4+c] XNOR w[k].
  - res[j] = 1 iff popcount of the 9 XNORs is >= 5; the count is 4 bits wide, 0..9.
- FSM states: IDLE, HDR, HDR_D, RD, RD_D, CMP, WR.
  - IDLE: when `dut_run`=1, go to HDR.
  - HDR: both read addresses = 0.
  - HDR_D: latch w_reg = wmem[8:0] and n_reg = sram[10:0]; clear i.
    - If n_reg = 0, go to IDLE; otherwise go to RD.
  - RD: sram read address = 1+i.
  - RD_D: latch in_reg = sram data.
  - CMP: res_reg <= core(in_reg, w_reg).
  - WR: write enable = 1, write address = OUT_BASE+i, write data = {12'b0, res_reg}; i <= i+1.
    - If i+1 == n_reg, go to IDLE; otherwise go to RD.
- Outputs:
  - `dut_busy` = (state != IDLE).
  - All outputs are driven from registers.
  - Write data and write address hold their last values outside WR.
  - Read addresses hold their value until the next RD or HDR.
- Boundary conditions:
  - `dut_run` while busy: ignored, with no restart and no queueing.
  - `dut_run` held high across the return to IDLE: starts a new job on the next cycle.
  - N = 0: no write is performed.
  - i and n_reg are 11 bits; i never wraps because the loop exits at i+1 == N. The maximum N is 2047, so no output address overlaps the input region.
- Reset behaviour:
  - `reset_b` low at any time immediately forces IDLE.
  - All outputs go to 0, and i, n_reg, w_reg, in_reg and res_reg are cleared.
  - An in-flight job is abandoned and no partial write occurs.

## Timing
- `dut_run` is sampled at edge E0; `dut_busy` = 1 from E0 onward.
- Memory latency: an address visible in cycle t returns data in cycle t+1.
- Per matrix: 4 cycles (RD, RD_D, CMP, WR).
- Per job: 2 + 4N busy cycles; `dut_busy` falls at the edge ending the last WR, or HDR_D when N = 0.
- Exactly one `dut_sram_write_enable` pulse per matrix.
- Exactly one WMEM read per job.

## Structure
- Package `bcnn_pkg`:
  - state enum `seq_state_t`;
  - `HDR_ADDR` = 12'h000;
  - `POP_THRESH` = 4'd5;
  - `WIN_BASE` = {0, 1, 4, 5}.
- Sub-module `bcnn_conv4x4_core`:
  - purely combinational;
  - inputs `in[15:0]` and `w[8:0]`, output `res[3:0]`;
  - uses the package constants.
- The sequencer holds the FSM, counters and datapath registers.

## Test plan
- Reset:
  - Assert `reset_b`=0 with random inputs.
  - All outputs read 0, state is IDLE, and no write occurs for 10 cycles with `dut_run`=0.
- Single matrix:
  - WMEM[0]=0x01FF, SRAM[0]=1, SRAM[1]=0xFFFF, pulse `dut_run`.
  - Busy lasts 6 cycles and produces one write: SRAM[0x800]=0x000F.
- Threshold boundary:
  - SRAM[1]=0x0000 and WMEM[0]=0x000F (5 matches) gives SRAM[0x800]=0x000F.
  - Rerun with WMEM[0]=0x001F (4 matches): SRAM[0x800]=0x0000.
- Empty job:
  - SRAM[0]=0.
  - Busy lasts exactly 2 cycles and `dut_sram_write_enable` never asserts.
- Multi-matrix with ignored run:
  - N=3, SRAM[1..3]=0xFFFF, 0x0000, 0xFFFF, WMEM[0]=0x01FF.
  - Pulse `dut_run` again mid-job.
  - Writes occur at 0x800/0x801/0x802 = 0x000F/0x0000/0x000F; busy lasts 14 cycles and there is no second job.
- Reset mid-operation:
  - Assert `reset_b` during the first CMP of an N=3 job.
  - Outputs go immediately to 0 and no write occurs.
  - A subsequent `dut_run` completes the full job correctly.

Source files
------------

// File: rtl/bcnn_pkg.sv
// bcnn_pkg: shared types and constants for the binary CNN run sequencer.
// Holds the sequencer state enum, the header address, the popcount threshold
// and the base bit offsets of the four 3x3 windows inside a 4x4 matrix.
package bcnn_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    HDR_D = 3'd2,
    RD    = 3'd3,
    RD_D  = 3'd4,
    CMP   = 3'd5,
    WR    = 3'd6
  } seq_state_t;

  localparam logic [11:0] HDR_ADDR   = 12'h000;
  localparam logic [3:0]  POP_THRESH = 4'd5;

  // Window base offsets packed LSB-first: window 0 -> 0, 1 -> 1, 2 -> 4, 3 -> 5.
  localparam logic [15:0] WIN_BASE = {4'd5, 4'd4, 4'd1, 4'd0};

  function automatic logic [3:0] win_base(input logic [1:0] j);
    return WIN_BASE[{j, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/bcnn_conv4x4_core.sv
// bcnn_conv4x4_core: combinational XNOR/popcount convolution of a 4x4 binary
// matrix with a 3x3 binary kernel, producing the four valid-window outputs.
// Ports:
//   in  [15:0] : matrix, bit r*4+c = element (r,c)
//   w   [8:0]  : kernel, bit r*3+c = tap (r,c)
//   res [3:0]  : res[j] = 1 when window j matches the kernel in >= 5 taps
module bcnn_conv4x4_core
  import bcnn_pkg::*;
(
  input  logic [15:0] in,
  input  logic [8:0]  w,
  output logic [3:0]  res
);

  // Count of matching taps for one window; the result fits in 4 bits (0..9).
  function automatic logic [3:0] win_count(input logic [15:0] in_v,
                                           input logic [8:0]  w_v,
                                           input logic [1:0]  j);
    logic [3:0] cnt;
    logic [3:0] idx;
    cnt = 4'd0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        idx = win_base(j) + 4'(r * 4 + c);
        cnt = cnt + {3'b000, ~(in_v[idx] ^ w_v[4'(r * 3 + c)])};
      end
    end
    return cnt;
  endfunction

  for (genvar j = 0; j < 4; j++) begin : g_win
    assign res[j] = (win_count(in, w, 2'(j)) >= POP_THRESH);
  end

endmodule

// File: rtl/bcnn_conv_sequencer.sv
// bcnn_conv_sequencer: run-level controller for the single-stage binary CNN.
// On dut_run it reads the kernel from WMEM[0] and the matrix count N from
// SRAM[0], then for each matrix i reads SRAM[1+i], convolves it and writes
// the 4-bit result to SRAM[OUT_BASE+i]. All outputs come straight from flops.
// Ports:
//   clk, reset_b                    : clock, async active-low reset
//   dut_run / dut_busy              : start request / job in progress
//   dut_sram_read_address, sram_dut_read_data   : SRAM read port (1-cycle latency)
//   dut_wmem_read_address, wmem_dut_read_data   : WMEM read port (1-cycle latency)
//   dut_sram_write_address/_data/_enable         : SRAM write port
module bcnn_conv_sequencer
  import bcnn_pkg::*;
#(
  parameter logic [11:0] OUT_BASE = 12'h800
) (
  input  logic        clk,
  input  logic        reset_b,
  input  logic        dut_run,
  output logic        dut_busy,
  output logic [11:0] dut_sram_read_address,
  input  logic [15:0] sram_dut_read_data,
  output logic [11:0] dut_wmem_read_address,
  input  logic [15:0] wmem_dut_read_data,
  output logic [11:0] dut_sram_write_address,
  output logic [15:0] dut_sram_write_data,
  output logic        dut_sram_write_enable
);

  seq_state_t  state_q, state_d;
  logic [10:0] i_q, i_d;
  logic [10:0] n_q, n_d;
  logic [8:0]  w_q, w_d;
  logic [15:0] in_q, in_d;
  logic [3:0]  res_q, res_d;
  logic        busy_q, busy_d;
  logic [11:0] rd_addr_q, rd_addr_d;
  logic [11:0] wm_addr_q, wm_addr_d;
  logic [11:0] wr_addr_q, wr_addr_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic        we_q, we_d;
  logic [3:0]  core_res;
  logic [10:0] i_inc;

  bcnn_conv4x4_core u_core (
    .in  (in_q),
    .w   (w_q),
    .res (core_res)
  );

  // Next-state, counter and output-register computation.
  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    n_d       = n_q;
    w_d       = w_q;
    in_d      = in_q;
    res_d     = res_q;
    rd_addr_d = rd_addr_q;
    wm_addr_d = wm_addr_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    we_d      = 1'b0;
    i_inc     = i_q + 11'd1;

    case (state_q)
      IDLE: begin
        if (dut_run) begin
          state_d   = HDR;
          rd_addr_d = HDR_ADDR;
          wm_addr_d = HDR_ADDR;
        end else begin
          state_d = IDLE;
        end
      end
      HDR: state_d = HDR_D;
      HDR_D: begin
        // Header data is on the read buses this cycle; N comes straight off
        // SRAM so an empty job can exit without a spare cycle.
        w_d = wmem_dut_read_data[8:0];
        n_d = sram_dut_read_data[10:0];
        i_d = 11'd0;
        if (sram_dut_read_data[10:0] == 11'd0) begin
          state_d = IDLE;
        end else begin
          state_d   = RD;
          rd_addr_d = 12'd1;
        end
      end
      RD: state_d = RD_D;
      RD_D: begin
        in_d    = sram_dut_read_data;
        state_d = CMP;
      end
      CMP: begin
        // The write port is loaded here so the strobe and data are registered
        // and visible exactly during the WR cycle.
        res_d     = core_res;
        wr_data_d = {12'h000, core_res};
        wr_addr_d = OUT_BASE + {1'b0, i_q};
        we_d      = 1'b1;
        state_d   = WR;
      end
      WR: begin
        i_d = i_inc;
        if (i_inc == n_q) begin
          state_d = IDLE;
        end else begin
          state_d   = RD;
          rd_addr_d = 12'd1 + {1'b0, i_inc};
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q   <= IDLE;
      i_q       <= 11'd0;
      n_q       <= 11'd0;
      w_q       <= 9'd0;
      in_q      <= 16'd0;
      res_q     <= 4'd0;
      busy_q    <= 1'b0;
      rd_addr_q <= 12'd0;
      wm_addr_q <= 12'd0;
      wr_addr_q <= 12'd0;
      wr_data_q <= 16'd0;
      we_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      n_q       <= n_d;
      w_q       <= w_d;
      in_q      <= in_d;
      res_q     <= res_d;
      busy_q    <= busy_d;
      rd_addr_q <= rd_addr_d;
      wm_addr_q <= wm_addr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      we_q      <= we_d;
    end
  end

  assign dut_busy               = busy_q;
  assign dut_sram_read_address  = rd_addr_q;
  assign dut_wmem_read_address  = wm_addr_q;
  assign dut_sram_write_address = wr_addr_q;
  assign dut_sram_write_data    = wr_data_q;
  assign dut_sram_write_enable  = we_q;

endmodule

// File: tb/tb_bcnn_conv_sequencer.sv
// Testbench for bcnn_conv_sequencer: SRAM/WMEM models with one-cycle read
// latency, a table of directed jobs with hand-computed results, plus hand
// sequences for reset, run-held-high restart and reset in the middle of a job.
module tb_bcnn_conv_sequencer;

  localparam int OUT_BASE_I = 'h800;

  logic        clk;
  logic        reset_b;
  logic        dut_run;
  logic        dut_busy;
  logic [11:0] dut_sram_read_address;
  logic [15:0] sram_dut_read_data;
  logic [11:0] dut_wmem_read_address;
  logic [15:0] wmem_dut_read_data;
  logic [11:0] dut_sram_write_address;
  logic [15:0] dut_sram_write_data;
  logic        dut_sram_write_enable;

  logic [15:0] sram [4096];
  logic [15:0] wmem [4096];
  logic        h_we;
  logic [11:0] h_addr;
  logic [15:0] h_data;
  int          wr_total;
  int          checks;
  int          errors;

  typedef struct {
    logic [15:0] wm;
    logic [15:0] hdr;
    logic [15:0] m0, m1, m2;
    logic [3:0]  r0, r1, r2;
    int          mid;
  } vec_t;

  vec_t vecs [7];

  bcnn_conv_sequencer dut (
    .clk                    (clk),
    .reset_b                (reset_b),
    .dut_run                (dut_run),
    .dut_busy               (dut_busy),
    .dut_sram_read_address  (dut_sram_read_address),
    .sram_dut_read_data     (sram_dut_read_data),
    .dut_wmem_read_address  (dut_wmem_read_address),
    .wmem_dut_read_data     (wmem_dut_read_data),
    .dut_sram_write_address (dut_sram_write_address),
    .dut_sram_write_data    (dut_sram_write_data),
    .dut_sram_write_enable  (dut_sram_write_enable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory models: host loads through a write port, DUT writes results.
  always @(posedge clk) begin
    if (h_we) sram[h_addr] <= h_data;
    else if (dut_sram_write_enable) sram[dut_sram_write_address] <= dut_sram_write_data;
    sram_dut_read_data <= sram[dut_sram_read_address];
    wmem_dut_read_data <= wmem[dut_wmem_read_address];
  end

  // Running count of write strobes seen.
  always @(negedge clk) begin
    if (dut_sram_write_enable) wr_total <= wr_total + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic host_wr(input int addr, input logic [15:0] data);
    @(negedge clk);
    h_we = 1'b1; h_addr = 12'(addr); h_data = data;
    @(negedge clk);
    h_we = 1'b0;
  endtask

  task automatic load_vec(input vec_t v);
    wmem[0] = v.wm;
    host_wr(0, v.hdr);
    host_wr(1, v.m0);
    host_wr(2, v.m1);
    host_wr(3, v.m2);
    for (int i = 0; i < 4; i++) host_wr(OUT_BASE_I + i, 16'hDEAD);
  endtask

  task automatic do_vec(input int k);
    vec_t v;
    logic [3:0] rr [3];
    int n, busy_cyc, w0;
    v = vecs[k];
    rr[0] = v.r0; rr[1] = v.r1; rr[2] = v.r2;
    load_vec(v);
    n  = int'(v.hdr[10:0]);
    w0 = wr_total;
    @(negedge clk); dut_run = 1'b1;
    @(posedge clk); #1; dut_run = 1'b0;
    busy_cyc = 0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (!dut_busy) break;
      busy_cyc++;
      dut_run = (v.mid != 0 && busy_cyc == 5) ? 1'b1 : 1'b0;
    end
    dut_run = 1'b0;
    chk($sformatf("v%0d busy_cycles", k), busy_cyc, 2 + 4 * n);
    repeat (3) @(negedge clk);
    chk($sformatf("v%0d no_restart", k), {31'b0, dut_busy}, 0);
    chk($sformatf("v%0d write_count", k), wr_total - w0, n);
    for (int i = 0; i < n; i++)
      chk($sformatf("v%0d result%0d", k, i), {16'b0, sram[OUT_BASE_I + i]}, {28'b0, rr[i]});
    chk($sformatf("v%0d sentinel", k), {16'b0, sram[OUT_BASE_I + n]}, 32'h0000DEAD);
    chk($sformatf("v%0d rd_addr_hold", k), {20'b0, dut_sram_read_address}, n);
    if (n > 0)
      chk($sformatf("v%0d wr_data_hold", k), {16'b0, dut_sram_write_data}, {28'b0, rr[n-1]});
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int w0, busy_cyc;
    checks = 0; errors = 0; wr_total = 0;
    h_we = 1'b0; h_addr = 12'd0; h_data = 16'd0;
    dut_run = 1'b0;
    reset_b = 1'b0;

    //          wmem      hdr       m0        m1        m2        r0    r1    r2   mid
    vecs[0] = '{16'h01FF, 16'h0001, 16'hFFFF, 16'h0000, 16'h0000, 4'hF, 4'h0, 4'h0, 0};
    vecs[1] = '{16'h000F, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 4'hF, 4'h0, 4'h0, 0};
    vecs[2] = '{16'h001F, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 4'h0, 4'h0, 4'h0, 0};
    vecs[3] = '{16'h01FF, 16'h0003, 16'hFFFF, 16'h0000, 16'hFFFF, 4'hF, 4'h0, 4'hF, 1};
    vecs[4] = '{16'h01FF, 16'h0000, 16'hFFFF, 16'hFFFF, 16'hFFFF, 4'h0, 4'h0, 4'h0, 0};
    vecs[5] = '{16'h01FF, 16'h0003, 16'h0777, 16'hEEE0, 16'hFFFF, 4'h7, 4'hE, 4'hF, 0};
    vecs[6] = '{16'h0000, 16'hF802, 16'h0777, 16'h0000, 16'h0000, 4'h8, 4'hF, 4'h0, 0};

    // Reset with random run requests: everything stays at zero.
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      dut_run = 1'($urandom_range(0, 1));
      #1;
      chk("rst_busy", {31'b0, dut_busy}, 0);
      chk("rst_we", {31'b0, dut_sram_write_enable}, 0);
      chk("rst_addr", {20'b0, dut_sram_read_address | dut_wmem_read_address
                              | dut_sram_write_address}, 0);
      chk("rst_wdata", {16'b0, dut_sram_write_data}, 0);
    end
    @(negedge clk);
    dut_run = 1'b0;
    reset_b = 1'b1;
    w0 = wr_total;
    busy_cyc = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (dut_busy) busy_cyc++;
    end
    chk("idle_busy", busy_cyc, 0);
    chk("idle_writes", wr_total - w0, 0);

    for (int k = 0; k < 7; k++) do_vec(k);

    // Run held high across the return to IDLE starts a second job.
    load_vec(vecs[0]);
    w0 = wr_total;
    @(negedge clk); dut_run = 1'b1;
    busy_cyc = 0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (dut_busy) busy_cyc++;
      else if (busy_cyc > 0) break;
    end
    chk("held_first_busy", busy_cyc, 6);
    @(negedge clk);
    chk("held_restart", {31'b0, dut_busy}, 1);
    dut_run = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (!dut_busy) break;
    end
    chk("held_writes", wr_total - w0, 2);

    // Reset asserted during the first CMP of an N=3 job.
    load_vec(vecs[5]);
    w0 = wr_total;
    @(negedge clk); dut_run = 1'b1;
    @(posedge clk); #1; dut_run = 1'b0;
    repeat (4) @(posedge clk);
    #2; reset_b = 1'b0;
    #1;
    chk("mid_rst_busy", {31'b0, dut_busy}, 0);
    chk("mid_rst_we", {31'b0, dut_sram_write_enable}, 0);
    chk("mid_rst_addr", {20'b0, dut_sram_read_address | dut_wmem_read_address
                                | dut_sram_write_address}, 0);
    chk("mid_rst_wdata", {16'b0, dut_sram_write_data}, 0);
    repeat (3) @(negedge clk);
    reset_b = 1'b1;
    repeat (4) @(negedge clk);
    chk("mid_rst_writes", wr_total - w0, 0);
    chk("mid_rst_sentinel", {16'b0, sram[OUT_BASE_I]}, 32'h0000DEAD);
    do_vec(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
